// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg
//   Word-wide pipeline register with a valid/ready handshake, used between
//   barrel-shifter pipeline stages. A main register drives the output and a
//   skid register absorbs the one extra word that can arrive in the cycle a
//   downstream stall is first seen. This keeps throughput at one word per
//   cycle without any combinational path from out_ready to in_ready.
//   The set/reset/complement-output behaviour of the old bit-level cell is
//   kept at word granularity.
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous, active-high; empties the stage and loads
//               RESET_VAL into both data registers
//   set         synchronous; replaces held contents with one SET_VAL word
//   flush       synchronous; discards all held words (data regs untouched)
//   in_valid    upstream word valid
//   in_ready    stage can accept a word (registered)
//   in_data     upstream word
//   out_valid   out_data holds a valid word
//   out_ready   downstream accepts the word
//   out_data    main data register
//   out_data_n  bitwise complement of out_data
//   count       occupancy, 0..2
module pipe_stage_reg #(
    parameter int unsigned      WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
    parameter logic [WIDTH-1:0] SET_VAL   = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             set,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [WIDTH-1:0] out_data_n,
    output logic [1:0]       count
);

    // State encoding equals occupancy, so count is the state register itself.
    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] FULL  = 2'd2;

    logic [1:0]       state_q;
    logic [1:0]       state_nxt;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] main_nxt;
    logic [WIDTH-1:0] skid_q;
    logic [WIDTH-1:0] skid_nxt;
    logic             in_fire;
    logic             out_fire;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    // Next-state and data-write decode. Priority: flush > set > handshake.
    always_comb begin
        state_nxt = state_q;
        main_nxt  = main_q;
        skid_nxt  = skid_q;
        if (flush) begin
            // Words are dropped by state alone; data registers keep their value.
            state_nxt = EMPTY;
        end else if (set) begin
            // Any beat firing now is swallowed; any skid word is abandoned.
            state_nxt = ONE;
            main_nxt  = SET_VAL;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        main_nxt  = in_data;
                        state_nxt = ONE;
                    end
                end
                ONE: begin
                    if (in_fire && !out_fire) begin
                        skid_nxt  = in_data;
                        state_nxt = FULL;
                    end else if (in_fire && out_fire) begin
                        main_nxt = in_data;
                    end else if (out_fire) begin
                        state_nxt = EMPTY;
                    end
                end
                FULL: begin
                    // in_ready is low here, so only the drain side can fire.
                    if (out_fire) begin
                        main_nxt  = skid_q;
                        state_nxt = ONE;
                    end
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

    // ---- register stage boundary ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= EMPTY;
            main_q   <= RESET_VAL;
            skid_q   <= RESET_VAL;
            in_ready <= 1'b0;
        end else begin
            state_q  <= state_nxt;
            main_q   <= main_nxt;
            skid_q   <= skid_nxt;
            // Registered look-ahead: ready unless the stage is about to be full.
            in_ready <= (state_nxt != FULL);
        end
    end

    assign out_valid  = (state_q != EMPTY);
    assign count      = state_q;
    assign out_data   = main_q;
    assign out_data_n = ~main_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;

    localparam logic [63:0] W64_RST = 64'h5555_5555_5555_5555;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        set = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_data = '0;

    logic        in_ready, out_valid;
    logic [31:0] out_data, out_data_n;
    logic [1:0]  count;

    logic        w64_in_ready, w64_out_valid;
    logic [63:0] w64_in_data, w64_out_data, w64_out_data_n;
    logic [1:0]  w64_count;

    logic        w1_in_ready, w1_out_valid;
    logic [0:0]  w1_in_data, w1_out_data, w1_out_data_n;
    logic [1:0]  w1_count;

    assign w64_in_data = {~in_data, in_data};
    assign w1_in_data  = in_data[0:0];

    always #5 clk = ~clk;

    pipe_stage_reg #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .set(set), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_data_n(out_data_n), .count(count)
    );

    pipe_stage_reg #(.WIDTH(64), .RESET_VAL(W64_RST)) dut64 (
        .clk(clk), .reset(reset), .set(set), .flush(flush),
        .in_valid(in_valid), .in_ready(w64_in_ready), .in_data(w64_in_data),
        .out_valid(w64_out_valid), .out_ready(out_ready), .out_data(w64_out_data),
        .out_data_n(w64_out_data_n), .count(w64_count)
    );

    pipe_stage_reg #(.WIDTH(1)) dut1 (
        .clk(clk), .reset(reset), .set(set), .flush(flush),
        .in_valid(in_valid), .in_ready(w1_in_ready), .in_data(w1_in_data),
        .out_valid(w1_out_valid), .out_ready(out_ready), .out_data(w1_out_data),
        .out_data_n(w1_out_data_n), .count(w1_count)
    );

    // Reference model: an ordered list of words the stage currently owes
    // downstream. Each entry is the 64-bit word; the 32-bit and 1-bit stages
    // are expected to present its low slices.
    logic [63:0] q[$];
    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;
    bit model_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected-response producer: decides, just before the coming edge, what
    // that edge does to the list of owed words.
    always begin
        @(negedge clk);
        #2;
        if (model_en && !reset) begin
            if (flush) begin
                q.delete();
            end else if (set) begin
                q.delete();
                q.push_back(64'hFFFF_FFFF_FFFF_FFFF);
            end else if (in_valid && in_ready) begin
                q.push_back({~in_data, in_data});
            end
        end
    end

    // Monitor: compares what the stages present against the owed list and
    // retires the head word whenever downstream takes it.
    always begin
        @(negedge clk);
        if (chk_en && !reset) begin
            chk("count",       {62'd0, count},      64'(q.size()));
            chk("count64",     {62'd0, w64_count},  64'(q.size()));
            chk("count1",      {62'd0, w1_count},   64'(q.size()));
            chk("out_valid",   {63'd0, out_valid},  {63'd0, q.size() != 0});
            chk("in_ready",    {63'd0, in_ready},   {63'd0, q.size() < 2});
            chk("in_ready1",   {63'd0, w1_in_ready},{63'd0, q.size() < 2});
            chk("data_n32",    {32'd0, out_data_n}, {32'd0, ~out_data});
            chk("data_n64",    w64_out_data_n,      ~w64_out_data);
            chk("data_n1",     {63'd0, w1_out_data_n}, {63'd0, ~w1_out_data});
            if (q.size() != 0) begin
                chk("out_data32", {32'd0, out_data},     {32'd0, q[0][31:0]});
                chk("out_data64", w64_out_data,          q[0]);
                chk("out_data1",  {63'd0, w1_out_data},  {63'd0, q[0][0]});
                if (out_valid && out_ready) void'(q.pop_front());
            end
        end
    end

    // One cycle of stimulus, applied shortly after a rising edge.
    task automatic beat(input bit iv, input logic [31:0] d, input bit ordy,
                        input bit st = 1'b0, input bit fl = 1'b0);
        @(posedge clk);
        #1;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        set       = st;
        flush     = fl;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_out_valid"}, {63'd0, out_valid}, 64'd0);
        chk({tag, "_count"},     {62'd0, count},     64'd0);
        chk({tag, "_in_ready"},  {63'd0, in_ready},  64'd0);
        chk({tag, "_data32"},    {32'd0, out_data},  64'd0);
        chk({tag, "_data_n32"},  {32'd0, out_data_n}, 64'h0000_0000_FFFF_FFFF);
        chk({tag, "_data64"},    w64_out_data,       W64_RST);
        chk({tag, "_data_n64"},  w64_out_data_n,     ~W64_RST);
        chk({tag, "_data_n1"},   {63'd0, w1_out_data_n}, 64'd1);
    endtask

    // Release reset between edges; ready must wait for the next rising edge.
    task automatic release_reset();
        #1;
        reset = 1'b0;
        #1;
        chk("ready_before_edge", {63'd0, in_ready}, 64'd0);
        @(posedge clk);
        #1;
        chk("ready_after_edge", {63'd0, in_ready}, 64'd1);
        chk_en   = 1'b1;
        model_en = 1'b1;
    endtask

    initial begin
        // Power-on reset, sampled mid-cycle.
        #12;
        check_reset_state("por");
        release_reset();

        // Streaming with downstream always ready.
        beat(1, 32'h1, 1);
        beat(1, 32'h2, 1);
        beat(1, 32'h3, 1);
        beat(0, 32'h0, 1);
        beat(0, 32'h0, 1);

        // Backpressure: two words fill the stage, then drain in order.
        beat(1, 32'hA, 0);
        beat(1, 32'hB, 0);
        beat(0, 32'h0, 0);
        beat(0, 32'h0, 0);
        chk("bp_full", {62'd0, count}, 64'd2);
        beat(0, 32'h0, 1);
        beat(0, 32'h0, 1);
        beat(0, 32'h0, 1);

        // Simultaneous accept and deliver while holding one word.
        beat(1, 32'h5, 0);
        beat(1, 32'h6, 1);
        beat(0, 32'h0, 0);
        #1;
        chk("simul_data", {32'd0, out_data}, 64'h6);
        chk("simul_count", {62'd0, count}, 64'd1);
        beat(0, 32'h0, 1);
        beat(0, 32'h0, 1);

        // Set while full: skid word is abandoned, SET_VAL presented.
        beat(1, 32'h7, 0);
        beat(1, 32'h8, 0);
        beat(0, 32'h0, 0, 1'b1, 1'b0);
        beat(0, 32'h0, 0);
        #1;
        chk("set_data", {32'd0, out_data}, 64'hFFFF_FFFF);
        chk("set_count", {62'd0, count}, 64'd1);
        beat(0, 32'h0, 1);
        // Set and flush together, with a beat offered: flush wins.
        beat(1, 32'h9, 0, 1'b1, 1'b1);
        beat(0, 32'h0, 0);
        #1;
        chk("setflush_count", {62'd0, count}, 64'd0);
        chk("setflush_valid", {63'd0, out_valid}, 64'd0);

        // Randomised traffic.
        for (int i = 0; i < 500; i++) begin
            beat(($urandom % 4) != 0, $urandom, ($urandom % 3) != 0,
                 ($urandom % 40) == 0, ($urandom % 40) == 0);
        end

        // Asynchronous reset mid-cycle with the stage full.
        beat(1, 32'hC0DE_0001, 0);
        beat(1, 32'hC0DE_0002, 0);
        beat(0, 32'h0, 0);
        @(posedge clk);
        #2;
        chk("pre_reset_count", {62'd0, count}, 64'd2);
        chk_en   = 1'b0;
        model_en = 1'b0;
        reset    = 1'b1;
        #1;
        check_reset_state("async");
        q.delete();
        in_valid = 1'b1;
        in_data  = 32'h1234_5678;
        @(posedge clk);
        #1;
        check_reset_state("held");
        in_valid = 1'b0;
        release_reset();

        // Streaming again after reset, then drain with a bounded wait.
        beat(1, 32'h11, 1);
        beat(1, 32'h22, 1);
        beat(1, 32'h33, 1);
        beat(0, 32'h0, 1);
        for (int i = 0; i < 20 && q.size() != 0; i++) beat(0, 32'h0, 1);
        chk("drain_empty", 64'(q.size()), 64'd0);
        beat(0, 32'h0, 0);
        beat(0, 32'h0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
